riscv_instr_encoder: RTL and testbench
======================================

Name: riscv_instr_encoder

Overview:
- Inverse of the instruction decode path: takes an instruction request and emits the 32-bit RV32I machine word.
- The request carries a 5-bit `INS_*` code from instructions.v plus rd/rs1/rs2/imm fields.
- Encoded words are written sequentially into instruction memory through a write port with backpressure.
- Used by the test/boot loader to build programs in hardware without a precompiled hex file.

Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first written word.
- MEM_BYTES, 4096, instruction memory size in bytes; power of two, at least 8.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous active-low reset; all state clears while low.
- clear  input  1  synchronous: drops in-flight words, address back to BASE_ADDR, counters zeroed.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready at a rising edge.
- in_op  input  5  `INS_*` code.
- in_rd, in_rs1, in_rs2  input  5 each  register indices.
- in_imm  input  32  signed immediate; byte offset for branch/JAL.
- mem_we  output  1  write valid.
- mem_ready  input  1  memory accepts the word when mem_we && mem_ready.
- mem_addr  output  32  byte address, word aligned.
- mem_wdata  output  32  encoded instruction.
- word_count  output  16  words written since reset/clear; saturates at 16'hFFFF.
- err  output  1  sticky: an illegal request was dropped.
- err_count  output  8  dropped requests; saturating.

Behaviour:
- Reset values:
  - in_ready = 1.
  - mem_we = 0, mem_wdata = 0.
  - mem_addr = BASE_ADDR.
  - word_count = 0, err = 0, err_count = 0.
- Two-stage pipeline:
  - S1 is the encode register: s1_valid, s1_word, s1_bad.
  - S2 is the output register driving mem_we / mem_wdata.
- S1 loads on in_valid && in_ready.
  - The word is encoded combinationally from the in_* fields.
  - Format per opcode:
    - R: ADD/SUB/SLL/SRL/XOR/OR/AND; SUB uses funct7 = 0100000.
    - I: ADDI/XORI/ORI/ANDI/LW/JALR.
    - I-shift: SLLI/SRLI, shamt = imm[4:0], funct7 = 0.
    - S: SW.
    - B: BEQ/BNE/BLT/BGE.
    - J: JAL.
    - ECALL = 32'h0000_0073.
  - Field placement and funct3 follow RV32I exactly.
  - Unused register fields are zero in the emitted word.
- S1 advances to S2 when S2 is empty or (mem_we && mem_ready).
- in_ready = !s1_valid || s1_advance, a single-level pipeline ready. Full throughput is one word/cycle while mem_ready = 1.
- Latency: a request accepted at edge N produces mem_we = 1 after edge N+1, provided no stall.
- While mem_we = 1 && mem_ready = 0, mem_addr and mem_wdata hold stable.
- On an accepted write (mem_we && mem_ready):
  - mem_addr += 4; on reaching BASE_ADDR + MEM_BYTES it wraps to BASE_ADDR.
  - word_count increments.
- Illegal request: in_op not in the supported set, or an immediate check failure (see feature).
  - Sets s1_bad. On advance the word is dropped: S2 is not loaded and the address is unchanged.
  - err is set and err_count increments, both in the advance cycle.
  - A dropped word is removed from S1 regardless of S2 state and never stalls.
- clear with a simultaneous accept: clear wins. The request is discarded, S1 and S2 empty, and in_ready is 1 the next cycle.
- clear does not reset err; err only clears on reset.
- Reset asserted mid-write: mem_we drops immediately (asynchronous); the word is lost.

Optional Feature:
- Macro: ENC_IMM_CHECK_EN.
- Defined: a request is illegal if any of these fail:
  - I/S imm is outside [-2048, 2047].
  - SLLI/SRLI imm is outside [0, 31].
  - B imm is odd or outside [-4096, 4094].
  - JAL imm is odd or outside [-1048576, 1048574].
- Not defined: immediates are silently truncated to the format's field bits; imm[0] is ignored for B and J. Only unsupported in_op is illegal.

Test Plan:
- ADDI rd=1 rs1=0 imm=5, mem_ready=1 -> mem_wdata=32'h00500093 at mem_addr=BASE_ADDR, mem_we one cycle after accept; word_count=1.
- Back-to-back ADD x3,x1,x2 then SUB x3,x1,x2 then LW x5,4(x1) -> 32'h002081B3, 32'h402081B3, 32'h0040A283 at addresses 0, 4, 8 on consecutive cycles.
- SW x2,8(x1), BEQ x1,x2,+8, JAL x1,+16, ECALL, with mem_ready low for 3 cycles on the second word -> 32'h0020A423, 32'h00208463, 32'h010000EF, 32'h00000073. mem_addr/mem_wdata stable during the stall; in_ready low once S1 is full.
- Invalid in_op between two ADDIs -> err=1, err_count=1, ADDIs at consecutive addresses 0 and 4.
- With ENC_IMM_CHECK_EN, BEQ imm=3 -> dropped, err=1. Without it -> imm 2 encoded, 32'h00208163 for BEQ x1,x2.
- MEM_BYTES=8: three writes -> addresses 0, 4, 0. Then clear mid-stall -> mem_we=0 next cycle, mem_addr=BASE_ADDR, word_count=0, err unchanged. Then reset low mid-write -> all outputs at reset values immediately.

Source files
------------

// File: rtl/riscv_instr_encoder_if.sv
// Request and instruction-memory write bus of riscv_instr_encoder.
// master: the side issuing requests and owning the memory (loader/bench).
// slave : the encoder itself.
interface riscv_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        mem_we;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/riscv_instr_encoder.sv
// RV32I instruction encoder: turns an INS_* request into a machine word and
// streams it into instruction memory through a two-stage pipeline
// (S1 encode register, S2 output register) with memory backpressure.
// Optional macro ENC_IMM_CHECK_EN: out-of-range or misaligned immediates make
// the request illegal; otherwise immediates are truncated to their fields.
module riscv_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  riscv_instr_encoder_if.slave    bus,
  output logic [15:0]             word_count,
  output logic                    err,
  output logic [7:0]              err_count
);

  localparam logic [4:0] INS_ADD = 5'd0,  INS_SUB = 5'd1,  INS_SLL = 5'd2,
                         INS_SRL = 5'd3,  INS_XOR = 5'd4,  INS_OR = 5'd5,
                         INS_AND = 5'd6,  INS_ADDI = 5'd7, INS_XORI = 5'd8,
                         INS_ORI = 5'd9,  INS_ANDI = 5'd10, INS_LW = 5'd11,
                         INS_JALR = 5'd12, INS_SLLI = 5'd13, INS_SRLI = 5'd14,
                         INS_SW = 5'd15,  INS_BEQ = 5'd16, INS_BNE = 5'd17,
                         INS_BLT = 5'd18, INS_BGE = 5'd19, INS_JAL = 5'd20,
                         INS_ECALL = 5'd21;

  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011,
                         OPC_LOAD = 7'b0000011, OPC_JALR = 7'b1100111,
                         OPC_STORE = 7'b0100011, OPC_BR = 7'b1100011,
                         OPC_JAL = 7'b1101111;

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_SH = 3'd2,
                         FMT_S = 3'd3, FMT_B = 3'd4, FMT_J = 3'd5,
                         FMT_SYS = 3'd6, FMT_BAD = 3'd7;

  localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(MEM_BYTES);

  logic        s1_valid, s1_bad, s2_valid;
  logic [31:0] s1_word, s2_word, addr;
  logic [2:0]  fmt, f3;
  logic [6:0]  opc, f7;
  logic [31:0] imm, enc_word;
  logic        imm_ok, enc_bad;
  logic        accept, mem_fire, s2_free, s1_advance;
  logic        unused_imm_bits;

  assign imm             = bus.in_imm;
  assign unused_imm_bits = &{1'b0, imm[31:21], imm[0]};

  assign mem_fire   = s2_valid && bus.mem_ready;
  assign s2_free    = !s2_valid || bus.mem_ready;
  // A bad word never waits for S2: it is simply discarded.
  assign s1_advance = s1_valid && (s1_bad || s2_free);
  assign bus.in_ready = !s1_valid || s1_advance;
  assign accept     = bus.in_valid && bus.in_ready;

  assign bus.mem_we    = s2_valid;
  assign bus.mem_wdata = s2_word;
  assign bus.mem_addr  = addr;

  // Map the request code to its instruction format, opcode and function fields.
  always_comb begin
    fmt = FMT_BAD;
    opc = 7'h00;
    f3  = 3'b000;
    f7  = 7'h00;
    case (bus.in_op)
      INS_ADD:   begin fmt = FMT_R;  opc = OPC_OP; end
      INS_SUB:   begin fmt = FMT_R;  opc = OPC_OP; f7 = 7'b0100000; end
      INS_SLL:   begin fmt = FMT_R;  opc = OPC_OP; f3 = 3'b001; end
      INS_SRL:   begin fmt = FMT_R;  opc = OPC_OP; f3 = 3'b101; end
      INS_XOR:   begin fmt = FMT_R;  opc = OPC_OP; f3 = 3'b100; end
      INS_OR:    begin fmt = FMT_R;  opc = OPC_OP; f3 = 3'b110; end
      INS_AND:   begin fmt = FMT_R;  opc = OPC_OP; f3 = 3'b111; end
      INS_ADDI:  begin fmt = FMT_I;  opc = OPC_IMM; end
      INS_XORI:  begin fmt = FMT_I;  opc = OPC_IMM; f3 = 3'b100; end
      INS_ORI:   begin fmt = FMT_I;  opc = OPC_IMM; f3 = 3'b110; end
      INS_ANDI:  begin fmt = FMT_I;  opc = OPC_IMM; f3 = 3'b111; end
      INS_LW:    begin fmt = FMT_I;  opc = OPC_LOAD; f3 = 3'b010; end
      INS_JALR:  begin fmt = FMT_I;  opc = OPC_JALR; end
      INS_SLLI:  begin fmt = FMT_SH; opc = OPC_IMM; f3 = 3'b001; end
      INS_SRLI:  begin fmt = FMT_SH; opc = OPC_IMM; f3 = 3'b101; end
      INS_SW:    begin fmt = FMT_S;  opc = OPC_STORE; f3 = 3'b010; end
      INS_BEQ:   begin fmt = FMT_B;  opc = OPC_BR; end
      INS_BNE:   begin fmt = FMT_B;  opc = OPC_BR; f3 = 3'b001; end
      INS_BLT:   begin fmt = FMT_B;  opc = OPC_BR; f3 = 3'b100; end
      INS_BGE:   begin fmt = FMT_B;  opc = OPC_BR; f3 = 3'b101; end
      INS_JAL:   begin fmt = FMT_J;  opc = OPC_JAL; end
      INS_ECALL: fmt = FMT_SYS;
      default:   fmt = FMT_BAD;
    endcase
  end

  // Assemble the word for the selected format and judge the immediate.
  always_comb begin
    enc_word = 32'h0;
    imm_ok   = 1'b1;
    case (fmt)
      FMT_R:   enc_word = {f7, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, opc};
      FMT_I:   enc_word = {imm[11:0], bus.in_rs1, f3, bus.in_rd, opc};
      FMT_SH:  enc_word = {7'b0, imm[4:0], bus.in_rs1, f3, bus.in_rd, opc};
      FMT_S:   enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, f3, imm[4:0], opc};
      FMT_B:   enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, f3,
                           imm[4:1], imm[11], opc};
      FMT_J:   enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, opc};
      FMT_SYS: enc_word = 32'h0000_0073;
      default: enc_word = 32'h0;
    endcase
`ifdef ENC_IMM_CHECK_EN
    case (fmt)
      FMT_I, FMT_S: imm_ok = (imm[31:11] == {21{imm[11]}});
      FMT_SH:       imm_ok = (imm[31:5] == 27'h0);
      FMT_B:        imm_ok = !imm[0] && (imm[31:12] == {20{imm[12]}});
      FMT_J:        imm_ok = !imm[0] && (imm[31:20] == {12{imm[20]}});
      default:      imm_ok = 1'b1;
    endcase
`endif
  end

  assign enc_bad = (fmt == FMT_BAD) || !imm_ok;

  // S1: capture an accepted request; empties when its word moves on or is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_bad   <= 1'b0;
      s1_word  <= 32'h0;
    end else if (clear) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_bad   <= enc_bad;
      s1_word  <= enc_word;
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: hold the outgoing word until memory takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_word  <= 32'h0;
    end else if (clear) begin
      s2_valid <= 1'b0;
    end else if (s1_advance && !s1_bad) begin
      s2_valid <= 1'b1;
      s2_word  <= s1_word;
    end else if (mem_fire) begin
      s2_valid <= 1'b0;
    end
  end

  // Write address (wrapping inside the memory window) and written-word counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr       <= BASE_ADDR;
      word_count <= 16'h0;
    end else if (clear) begin
      addr       <= BASE_ADDR;
      word_count <= 16'h0;
    end else if (mem_fire) begin
      addr <= (addr + 32'd4 == END_ADDR) ? BASE_ADDR : addr + 32'd4;
      if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
    end
  end

  // Error flag is sticky until reset; the drop counter also zeroes on clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err       <= 1'b0;
      err_count <= 8'h0;
    end else if (clear) begin
      err_count <= 8'h0;
    end else if (s1_advance && s1_bad) begin
      err <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_riscv_instr_encoder.sv
module tb_riscv_instr_encoder;

  localparam logic [31:0] BASE_A = 32'h0000_0000;
  localparam int          MEM_A  = 4096;
  localparam logic [31:0] BASE_B = 32'h0000_1000;
  localparam int          MEM_B  = 8;

  localparam int OP_ADD = 0, OP_SUB = 1, OP_LW = 11, OP_ADDI = 7, OP_SW = 15,
                 OP_BEQ = 16, OP_JAL = 20, OP_ECALL = 21;

  // funct3 per request code 0..21, straight from the RV32I tables
  int f3_of [22] = '{0,0,1,5,4,6,7, 0,4,6,7,2,0, 1,5, 2, 0,1,4,5, 0,0};

  logic clk, rst_n, clear;
  logic in_valid, mem_ready;
  logic [4:0] in_op, in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic [15:0] wc_a, wc_b;
  logic err_a, err_b;
  logic [7:0] ec_a, ec_b;

  riscv_instr_encoder_if ifa ();
  riscv_instr_encoder_if ifb ();

  assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;
  assign ifa.in_op = in_op;        assign ifb.in_op = in_op;
  assign ifa.in_rd = in_rd;        assign ifb.in_rd = in_rd;
  assign ifa.in_rs1 = in_rs1;      assign ifb.in_rs1 = in_rs1;
  assign ifa.in_rs2 = in_rs2;      assign ifb.in_rs2 = in_rs2;
  assign ifa.in_imm = in_imm;      assign ifb.in_imm = in_imm;
  assign ifa.mem_ready = mem_ready; assign ifb.mem_ready = mem_ready;

  riscv_instr_encoder #(.BASE_ADDR(BASE_A), .MEM_BYTES(MEM_A)) dut_a (
    .clk(clk), .reset(rst_n), .clear(clear), .bus(ifa.slave),
    .word_count(wc_a), .err(err_a), .err_count(ec_a));

  riscv_instr_encoder #(.BASE_ADDR(BASE_B), .MEM_BYTES(MEM_B)) dut_b (
    .clk(clk), .reset(rst_n), .clear(clear), .bus(ifb.slave),
    .word_count(wc_b), .err(err_b), .err_count(ec_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // ---------------- reference model (RV32I encoding rules) ----------------
  function automatic bit [31:0] ref_encode(int op, int rd, int rs1, int rs2, int imm);
    bit [31:0] u, d, a, b, f3, opc;
    u = imm; d = rd; a = rs1; b = rs2;
    if (op > 21) return 32'h0;
    f3 = f3_of[op];
    if (op <= 6)
      return 32'h33 + (d << 7) + (f3 << 12) + (a << 15) + (b << 20) + ((op == OP_SUB) ? (32'd32 << 25) : 0);
    if (op <= 12) begin
      opc = (op == 11) ? 32'h03 : (op == 12) ? 32'h67 : 32'h13;
      return opc + (d << 7) + (f3 << 12) + (a << 15) + ((u & 32'hFFF) << 20);
    end
    if (op <= 14)
      return 32'h13 + (d << 7) + (f3 << 12) + (a << 15) + ((u & 32'h1F) << 20);
    if (op == 15)
      return 32'h23 + ((u & 31) << 7) + (f3 << 12) + (a << 15) + (b << 20) + (((u >> 5) & 127) << 25);
    if (op <= 19)
      return 32'h63 + (((u >> 11) & 1) << 7) + (((u >> 1) & 15) << 8) + (f3 << 12) + (a << 15)
             + (b << 20) + (((u >> 5) & 63) << 25) + (((u >> 12) & 1) << 31);
    if (op == 20)
      return 32'h6F + (d << 7) + (((u >> 12) & 255) << 12) + (((u >> 11) & 1) << 20)
             + (((u >> 1) & 1023) << 21) + (((u >> 20) & 1) << 31);
    return 32'h73;
  endfunction

  function automatic bit ref_legal(int op, int imm);
    if (op < 0 || op > 21) return 1'b0;
`ifdef ENC_IMM_CHECK_EN
    if ((op >= 7 && op <= 12) || op == 15) return (imm >= -2048 && imm <= 2047);
    if (op == 13 || op == 14) return (imm >= 0 && imm <= 31);
    if (op >= 16 && op <= 19) return ((imm & 1) == 0) && imm >= -4096 && imm <= 4094;
    if (op == 20) return ((imm & 1) == 0) && imm >= -1048576 && imm <= 1048574;
`endif
    return 1'b1;
  endfunction

  // ---------------- scoreboard / per-cycle compare ----------------
  bit [31:0] exp_q[$];
  bit [31:0] log_data[$], log_addr_a[$], log_addr_b[$];
  int log_cyc[$];
  int cyc = 0;
  int m_wc = 0, m_ec = 0, off_a = 0, off_b = 0;
  bit m_err = 0, pend = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      m_wc = 0; m_ec = 0; off_a = 0; off_b = 0; m_err = 0; pend = 0;
    end else begin
      chk("word_count_a", 32'(wc_a), 32'(m_wc));
      chk("word_count_b", 32'(wc_b), 32'(m_wc));
      chk("err_a", 32'(err_a), 32'(m_err));
      chk("err_b", 32'(err_b), 32'(m_err));
      chk("err_count_a", 32'(ec_a), 32'(m_ec));
      chk("err_count_b", 32'(ec_b), 32'(m_ec));
      chk("mem_addr_a", ifa.mem_addr, BASE_A + 32'(off_a));
      chk("mem_addr_b", ifb.mem_addr, BASE_B + 32'(off_b));
      if (ifa.mem_we) begin
        if (exp_q.size() == 0) fail_now("unexpected_write_a");
        else chk("mem_wdata_a", ifa.mem_wdata, exp_q[0]);
      end
      if (ifb.mem_we) begin
        if (exp_q.size() == 0) fail_now("unexpected_write_b");
        else chk("mem_wdata_b", ifb.mem_wdata, exp_q[0]);
      end
      if (clear) begin
        exp_q.delete();
        m_wc = 0; m_ec = 0; off_a = 0; off_b = 0; pend = 0;
      end else begin
        if (ifa.mem_we && mem_ready && exp_q.size() > 0) begin
          log_data.push_back(ifa.mem_wdata);
          log_addr_a.push_back(ifa.mem_addr);
          log_addr_b.push_back(ifb.mem_addr);
          log_cyc.push_back(cyc);
          void'(exp_q.pop_front());
          if (m_wc < 65535) m_wc++;
          off_a = (off_a + 4) % MEM_A;
          off_b = (off_b + 4) % MEM_B;
        end
        if (pend) begin
          m_err = 1;
          if (m_ec < 255) m_ec++;
        end
        pend = 0;
        if (in_valid && ifa.in_ready) begin
          if (ref_legal(int'(in_op), int'($signed(in_imm))))
            exp_q.push_back(ref_encode(int'(in_op), int'(in_rd), int'(in_rs1), int'(in_rs2), int'($signed(in_imm))));
          else
            pend = 1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input int op, input int rd, input int rs1, input int rs2, input int imm);
    bit done;
    done = 0;
    in_valid = 1'b1;
    in_op = op[4:0]; in_rd = rd[4:0]; in_rs1 = rs1[4:0]; in_rs2 = rs2[4:0]; in_imm = imm;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = ifa.in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) fail_now("send_timeout");
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic wait_we();
    bit seen;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); #1;
      seen = ifa.mem_we;
    end
    if (!seen) fail_now("wait_mem_we_timeout");
  endtask

  task automatic stall_ctrl();
    bit seen;
    logic [31:0] hold_addr;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      seen = ifa.mem_we && (ifa.mem_wdata == 32'h00208463);
    end
    if (!seen) fail_now("t3_beq_never_in_s2");
    mem_ready = 1'b0;
    hold_addr = ifa.mem_addr;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_we", 32'(ifa.mem_we), 32'd1);
      chk("t3_stall_wdata", ifa.mem_wdata, 32'h00208463);
      chk("t3_stall_addr", ifa.mem_addr, hold_addr);
      chk("t3_in_ready_low", 32'(ifa.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  int base, ri;

  initial begin
    rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    in_op = 0; in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
    #2 rst_n = 1'b0;

    // pin the model against hand-encoded words
    chk("model_addi", ref_encode(OP_ADDI, 1, 0, 0, 5), 32'h00500093);
    chk("model_sub", ref_encode(OP_SUB, 3, 1, 2, 0), 32'h402081B3);
    chk("model_sw", ref_encode(OP_SW, 0, 1, 2, 8), 32'h0020A423);
    chk("model_beq", ref_encode(OP_BEQ, 0, 1, 2, 8), 32'h00208463);
    chk("model_jal", ref_encode(OP_JAL, 1, 0, 0, 16), 32'h010000EF);
    chk("model_jal_neg", ref_encode(OP_JAL, 0, 0, 0, -4), 32'hFFDFF06F);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_in_ready", 32'(ifa.in_ready), 32'd1);
    chk("rst_mem_we", 32'(ifa.mem_we), 32'd0);
    chk("rst_mem_wdata", ifa.mem_wdata, 32'd0);
    chk("rst_mem_addr", ifa.mem_addr, BASE_A);
    @(posedge clk); #1;

    // T1: single ADDI, latency
    send(OP_ADDI, 1, 0, 0, 5);
    @(negedge clk);
    chk("t1_we_not_yet", 32'(ifa.mem_we), 32'd0);
    @(negedge clk);
    chk("t1_we", 32'(ifa.mem_we), 32'd1);
    chk("t1_wdata", ifa.mem_wdata, 32'h00500093);
    chk("t1_addr", ifa.mem_addr, BASE_A);
    @(negedge clk);
    chk("t1_word_count", 32'(wc_a), 32'd1);
    @(posedge clk); #1;

    // T2: back-to-back R/R/LW
    pulse_clear();
    base = log_data.size();
    send(OP_ADD, 3, 1, 2, 0);
    send(OP_SUB, 3, 1, 2, 0);
    send(OP_LW, 5, 1, 0, 4);
    idle(5);
    chk("t2_nwrites", 32'(log_data.size() - base), 32'd3);
    if (log_data.size() - base == 3) begin
      chk("t2_w0", log_data[base], 32'h002081B3);
      chk("t2_w1", log_data[base+1], 32'h402081B3);
      chk("t2_w2", log_data[base+2], 32'h0040A283);
      chk("t2_a2", log_addr_a[base+2], BASE_A + 32'd8);
      chk("t2_consec", 32'(log_cyc[base+2] - log_cyc[base]), 32'd2);
    end

    // T3: SW/BEQ/JAL/ECALL with a 3-cycle stall on BEQ
    base = log_data.size();
    fork
      begin
        send(OP_SW, 0, 1, 2, 8);
        send(OP_BEQ, 0, 1, 2, 8);
        send(OP_JAL, 1, 0, 0, 16);
        send(OP_ECALL, 0, 0, 0, 0);
      end
      stall_ctrl();
    join
    idle(6);
    chk("t3_nwrites", 32'(log_data.size() - base), 32'd4);
    if (log_data.size() - base == 4) begin
      chk("t3_w0", log_data[base], 32'h0020A423);
      chk("t3_w1", log_data[base+1], 32'h00208463);
      chk("t3_w2", log_data[base+2], 32'h010000EF);
      chk("t3_w3", log_data[base+3], 32'h00000073);
    end

    // T4: illegal op between two ADDIs
    pulse_clear();
    base = log_data.size();
    send(OP_ADDI, 1, 0, 0, 5);
    send(31, 1, 1, 1, 0);
    send(OP_ADDI, 2, 0, 0, 7);
    idle(5);
    chk("t4_err", 32'(err_a), 32'd1);
    chk("t4_err_count", 32'(ec_a), 32'd1);
    chk("t4_nwrites", 32'(log_data.size() - base), 32'd2);
    if (log_data.size() - base == 2) begin
      chk("t4_a0", log_addr_a[base], BASE_A);
      chk("t4_a1", log_addr_a[base+1], BASE_A + 32'd4);
      chk("t4_w1", log_data[base+1], 32'h00700113);
    end

    // T5: odd branch offset
    base = log_data.size();
    send(OP_BEQ, 0, 1, 2, 3);
    idle(5);
`ifdef ENC_IMM_CHECK_EN
    chk("t5_err_count", 32'(ec_a), 32'd2);
    chk("t5_nwrites", 32'(log_data.size() - base), 32'd0);
`else
    chk("t5_err_count", 32'(ec_a), 32'd1);
    chk("t5_nwrites", 32'(log_data.size() - base), 32'd1);
    if (log_data.size() - base == 1) chk("t5_word", log_data[base], 32'h00208163);
`endif

    // T6: wrap in an 8-byte window, clear mid-stall, reset mid-write
    pulse_clear();
    base = log_data.size();
    send(OP_ADDI, 1, 0, 0, 1);
    send(OP_ADDI, 1, 0, 0, 2);
    send(OP_ADDI, 1, 0, 0, 3);
    idle(5);
    chk("t6_nwrites", 32'(log_data.size() - base), 32'd3);
    if (log_data.size() - base == 3) begin
      chk("t6_b0", log_addr_b[base], BASE_B);
      chk("t6_b1", log_addr_b[base+1], BASE_B + 32'd4);
      chk("t6_b2", log_addr_b[base+2], BASE_B);
    end
    mem_ready = 1'b0;
    send(OP_ADDI, 4, 0, 0, 9);
    wait_we();
    pulse_clear();
    @(negedge clk);
    chk("t6_clr_we", 32'(ifa.mem_we), 32'd0);
    chk("t6_clr_addr_a", ifa.mem_addr, BASE_A);
    chk("t6_clr_addr_b", ifb.mem_addr, BASE_B);
    chk("t6_clr_wc", 32'(wc_a), 32'd0);
    chk("t6_clr_err", 32'(err_a), 32'd1);
    chk("t6_clr_in_ready", 32'(ifa.in_ready), 32'd1);
    @(posedge clk); #1;
    send(OP_ADDI, 4, 0, 0, 9);
    wait_we();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_we", 32'(ifa.mem_we), 32'd0);
    chk("t6_rst_wdata", ifa.mem_wdata, 32'd0);
    chk("t6_rst_addr_b", ifb.mem_addr, BASE_B);
    chk("t6_rst_err", 32'(err_a), 32'd0);
    chk("t6_rst_ec", 32'(ec_a), 32'd0);
    chk("t6_rst_wc", 32'(wc_b), 32'd0);
    chk("t6_rst_in_ready", 32'(ifa.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    idle(2);

    // Random phase: mixed legal/illegal requests, random backpressure, rare clears
    for (int c = 0; c < 3000; c++) begin
      in_valid = ($urandom % 10) < 7;
      in_op = ($urandom % 4 == 0) ? 5'($urandom_range(22, 31)) : 5'($urandom_range(0, 21));
      in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      ri = int'($urandom_range(0, 3));
      case (ri)
        0: in_imm = 32'(int'($urandom_range(0, 80)) - 40);
        1: in_imm = 32'(int'($urandom_range(0, 4200)) - 2100);
        2: in_imm = 32'(int'($urandom_range(0, 2097200)) - 1048600);
        default: in_imm = $urandom;
      endcase
      mem_ready = ($urandom % 10) < 7;
      clear = ($urandom % 300) == 0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    clear = 1'b0;
    mem_ready = 1'b1;
    idle(8);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
